ssd_sequence_entry: RTL and testbench

Parametrised successor to the four-digit sequence display/entry block for the bomb-squad puzzle. It latches a target symbol sequence and shows it on NUM_DIGITS seven-segment digits for SHOW_SECS one-second ticks. It then lets the player enter a sequence digit-by-digit with Move/Next buttons, and reports completion plus a match verdict to the game controller.

---
 rtl/ssd_sequence_entry.sv | 242 ++++++++++++++++++++++++
 tb/tb_ssd_sequence_entry.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_sequence_entry.sv
// ssd_sequence_entry
// Shows a latched target symbol sequence on NUM_DIGITS seven-segment digits
// for SHOW_SECS one-second ticks. The player then rebuilds the sequence with
// Move (rotate symbol under cursor) and Next (advance cursor / finish). The
// block then reports a one-cycle entry_done pulse and a held match verdict.
//
// Optional build macro: CURSOR_BLINK_EN
//   When defined, the digit under the cursor blanks on alternate OneSec ticks
//   during entry. Moving the cursor makes the new digit visible at once.
//
// Symbol codes are one-hot active-low over NUM_SYMBOLS bits.
// Symbol k has bit k low and every other bit high.
module ssd_sequence_entry #(
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_SYMBOLS = 4,
  parameter int SHOW_SECS   = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_DIGITS*NUM_SYMBOLS-1:0] Sequence_in,
  input  logic                              display,
  input  logic                              OneSec,
  input  logic                              ButtonMove,
  input  logic                              ButtonNext,
  output logic [7*NUM_DIGITS-1:0]           SevSeg,
  output logic [NUM_DIGITS*NUM_SYMBOLS-1:0] Sequence_out,
  output logic [2:0]                        cursor,
  output logic                              busy,
  output logic                              entry_done,
  output logic                              match
);

  localparam int SEQ_W = NUM_DIGITS * NUM_SYMBOLS;
  localparam int SEG_W = 7 * NUM_DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_ENTER = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam logic [NUM_SYMBOLS-1:0] SYM0_CODE = {{(NUM_SYMBOLS-1){1'b1}}, 1'b0};
  localparam logic [SEQ_W-1:0]       SEQ_SYM0  = {NUM_DIGITS{SYM0_CODE}};
  localparam logic [2:0]             LAST_CUR  = 3'(NUM_DIGITS - 1);
  localparam logic [3:0]             SHOW_LIM  = 4'(SHOW_SECS);

  localparam logic [6:0] GLYPH_SYM0  = 7'b1111110;
  localparam logic [6:0] GLYPH_SYM1  = 7'b1111001;
  localparam logic [6:0] GLYPH_SYM2  = 7'b1110111;
  localparam logic [6:0] GLYPH_SYM3  = 7'b1001111;
  localparam logic [6:0] GLYPH_ERR   = 7'b0100001;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Segment pattern for a symbol index.
  function automatic logic [6:0] sym_glyph_f(input logic [1:0] idx);
    logic [6:0] g;
    case (idx)
      2'd0:    g = GLYPH_SYM0;
      2'd1:    g = GLYPH_SYM1;
      2'd2:    g = GLYPH_SYM2;
      2'd3:    g = GLYPH_SYM3;
      default: g = GLYPH_ERR;
    endcase
    return g;
  endfunction

  // Decode a one-hot-low code to its glyph; anything else is the error glyph.
  function automatic logic [6:0] glyph_f(input logic [NUM_SYMBOLS-1:0] code);
    logic [6:0]             g;
    logic [NUM_SYMBOLS-1:0] ref_code;
    g = GLYPH_ERR;
    for (int k = 0; k < NUM_SYMBOLS; k++) begin
      ref_code = {{(NUM_SYMBOLS-1){1'b0}}, 1'b1} << k;
      ref_code = ~ref_code;
      if (code == ref_code) begin
        g = sym_glyph_f(2'(k));
      end else begin
        g = g;
      end
    end
    return g;
  endfunction

  // Next symbol in cyclic order. The low bit moves up one place, so the
  // top symbol wraps back to symbol 0.
  function automatic logic [NUM_SYMBOLS-1:0] rot_f(input logic [NUM_SYMBOLS-1:0] code);
    return {code[NUM_SYMBOLS-2:0], code[NUM_SYMBOLS-1]};
  endfunction

  logic [1:0]       state_q,  state_d;
  logic [SEQ_W-1:0] target_q, target_d;
  logic [SEQ_W-1:0] seq_q,    seq_d;
  logic [2:0]       cursor_q, cursor_d;
  logic [3:0]       cnt_q,    cnt_d;
  logic             match_q,  match_d;
  logic             done_q,   done_d;
  logic             busy_q,   busy_d;
  logic [SEG_W-1:0] sev_q,    sev_d;
`ifdef CURSOR_BLINK_EN
  logic             blink_q,  blink_d;
`endif

  // Round sequencing: capture, timed show, digit entry, verdict.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    seq_d    = seq_q;
    cursor_d = cursor_q;
    cnt_d    = cnt_q;
    match_d  = match_q;
`ifdef CURSOR_BLINK_EN
    blink_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (display) begin
          target_d = Sequence_in;
          match_d  = 1'b0;
          cnt_d    = 4'd0;
          state_d  = ST_SHOW;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (OneSec) begin
          cnt_d = cnt_q + 4'd1;
          if ((cnt_q + 4'd1) == SHOW_LIM) begin
            state_d  = ST_ENTER;
            seq_d    = SEQ_SYM0;
            cursor_d = 3'd0;
          end else begin
            state_d  = ST_SHOW;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ENTER: begin
`ifdef CURSOR_BLINK_EN
        if (ButtonNext) begin
          blink_d = 1'b0;
        end else if (OneSec) begin
          blink_d = ~blink_q;
        end else begin
          blink_d = blink_q;
        end
`endif
        // Next has priority; a Move in the same cycle is dropped.
        if (ButtonNext) begin
          if (cursor_q == LAST_CUR) begin
            state_d = ST_CHECK;
            match_d = (seq_q == target_q);
          end else begin
            cursor_d = cursor_q + 3'd1;
          end
        end else if (ButtonMove) begin
          for (int d = 0; d < NUM_DIGITS; d++) begin
            if (3'(d) == cursor_q) begin
              seq_d[d*NUM_SYMBOLS +: NUM_SYMBOLS] = rot_f(seq_q[d*NUM_SYMBOLS +: NUM_SYMBOLS]);
            end else begin
              seq_d[d*NUM_SYMBOLS +: NUM_SYMBOLS] = seq_q[d*NUM_SYMBOLS +: NUM_SYMBOLS];
            end
          end
        end else begin
          state_d = ST_ENTER;
        end
      end
      ST_CHECK: begin
        state_d  = ST_IDLE;
        cursor_d = 3'd0;
      end
      default: begin
        state_d  = ST_IDLE;
        cursor_d = 3'd0;
      end
    endcase
  end

  // Output images computed from next-state values so each registered output
  // agrees with the state register in the same cycle.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_CHECK);
    sev_d  = {SEG_W{1'b1}};
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (state_d == ST_SHOW) begin
        sev_d[d*7 +: 7] = glyph_f(target_d[d*NUM_SYMBOLS +: NUM_SYMBOLS]);
      end else if ((state_d == ST_ENTER) || (state_d == ST_CHECK)) begin
`ifdef CURSOR_BLINK_EN
        if ((state_d == ST_ENTER) && blink_d && (3'(d) == cursor_d)) begin
          sev_d[d*7 +: 7] = GLYPH_BLANK;
        end else begin
          sev_d[d*7 +: 7] = glyph_f(seq_d[d*NUM_SYMBOLS +: NUM_SYMBOLS]);
        end
`else
        sev_d[d*7 +: 7] = glyph_f(seq_d[d*NUM_SYMBOLS +: NUM_SYMBOLS]);
`endif
      end else begin
        sev_d[d*7 +: 7] = GLYPH_BLANK;
      end
    end
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= SEQ_SYM0;
      seq_q    <= SEQ_SYM0;
      cursor_q <= 3'd0;
      cnt_q    <= 4'd0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      sev_q    <= {SEG_W{1'b1}};
`ifdef CURSOR_BLINK_EN
      blink_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      seq_q    <= seq_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sev_q    <= sev_d;
`ifdef CURSOR_BLINK_EN
      blink_q  <= blink_d;
`endif
    end
  end

  assign SevSeg       = sev_q;
  assign Sequence_out = seq_q;
  assign cursor       = cursor_q;
  assign busy         = busy_q;
  assign entry_done   = done_q;
  assign match        = match_q;

endmodule

// File: tb/tb_ssd_sequence_entry.sv
// Scoreboard bench for ssd_sequence_entry (default parameters 4/4/2).
// Stimulus pushes expected snapshots and verdicts into queues; a monitor
// running on the falling edge pops and compares them against the DUT.
module tb_ssd_sequence_entry;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b1110111;
  localparam logic [6:0] G3 = 7'b1001111;
  localparam logic [6:0] GE = 7'b0100001;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [27:0] BLANK = {BL, BL, BL, BL};
  localparam logic [27:0] ALL0  = {G0, G0, G0, G0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Sequence_in = 16'h0000;
  logic        display = 1'b0;
  logic        OneSec = 1'b0;
  logic        ButtonMove = 1'b0;
  logic        ButtonNext = 1'b0;
  logic [27:0] SevSeg;
  logic [15:0] Sequence_out;
  logic [2:0]  cursor;
  logic        busy;
  logic        entry_done;
  logic        match;

  ssd_sequence_entry #(.NUM_DIGITS(4), .NUM_SYMBOLS(4), .SHOW_SECS(2)) dut (
    .clk(clk), .reset(reset), .Sequence_in(Sequence_in), .display(display),
    .OneSec(OneSec), .ButtonMove(ButtonMove), .ButtonNext(ButtonNext),
    .SevSeg(SevSeg), .Sequence_out(Sequence_out), .cursor(cursor),
    .busy(busy), .entry_done(entry_done), .match(match)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        full;
    logic [27:0] sev;
    logic [15:0] seq;
    logic [2:0]  cur;
    logic        busy;
    logic        match;
    logic        done;
  } snap_t;

  typedef struct {
    logic        m;
    logic [15:0] s;
  } verdict_t;

  snap_t    exp_q[$];
  verdict_t done_exp_q[$];
  int       tests = 0;
  int       fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_s(input string n, input logic full, input logic [27:0] sev,
                          input logic [15:0] seq, input logic [2:0] cur,
                          input logic b, input logic m, input logic d);
    snap_t s;
    s.name = n; s.full = full; s.sev = sev; s.seq = seq; s.cur = cur;
    s.busy = b; s.match = m; s.done = d;
    exp_q.push_back(s);
  endtask

  task automatic do_move(input int n);
    for (int i = 0; i < n; i++) begin
      ButtonMove = 1'b1; step(); ButtonMove = 1'b0; step();
    end
  endtask

  task automatic do_next();
    ButtonNext = 1'b1; step(); ButtonNext = 1'b0; step();
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      OneSec = 1'b1; step(); OneSec = 1'b0; step();
    end
  endtask

  task automatic final_next(input logic m, input logic [15:0] s);
    verdict_t v;
    v.m = m; v.s = s;
    done_exp_q.push_back(v);
    ButtonNext = 1'b1; step(); ButtonNext = 1'b0;
  endtask

  // Monitor: compare pending snapshots and every entry_done pulse.
  initial begin
    snap_t    s;
    verdict_t v;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        tests++;
        if ((s.full && (SevSeg !== s.sev || cursor !== s.cur)) ||
            Sequence_out !== s.seq || busy !== s.busy ||
            match !== s.match || entry_done !== s.done) begin
          fails++;
          $display("FAIL %s: got/exp sev=%h/%h seq=%h/%h cur=%0d/%0d busy=%b/%b match=%b/%b done=%b/%b",
                   s.name, SevSeg, s.sev, Sequence_out, s.seq, cursor, s.cur,
                   busy, s.busy, match, s.match, entry_done, s.done);
        end
      end
      if (entry_done === 1'b1) begin
        tests++;
        if (done_exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: entry_done=1 with no verdict expected (seq=%h match=%b)",
                   Sequence_out, match);
        end else begin
          v = done_exp_q.pop_front();
          if (match !== v.m || Sequence_out !== v.s) begin
            fails++;
            $display("FAIL verdict: got/exp match=%b/%b seq=%h/%h", match, v.m, Sequence_out, v.s);
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    step(); step();
    expect_s("reset", 1'b1, BLANK, 16'hEEEE, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();

    // Round A: target EDB7, entry ends up EDE7 (digit1 left wrong).
    Sequence_in = 16'hEDB7; display = 1'b1; step(); display = 1'b0;
    Sequence_in = 16'h0000;
    expect_s("show", 1'b1, {G0, G1, G2, G3}, 16'hEEEE, 3'd0, 1'b1, 1'b0, 1'b0);
    do_tick(1);
    expect_s("show_t1", 1'b1, {G0, G1, G2, G3}, 16'hEEEE, 3'd0, 1'b1, 1'b0, 1'b0);
    do_tick(1);
    expect_s("enter", 1'b1, ALL0, 16'hEEEE, 3'd0, 1'b1, 1'b0, 1'b0);
    do_move(1);
    expect_s("move1", 1'b1, {G0, G0, G0, G1}, 16'hEEED, 3'd0, 1'b1, 1'b0, 1'b0);
    do_move(2);
    expect_s("move3", 1'b1, {G0, G0, G0, G3}, 16'hEEE7, 3'd0, 1'b1, 1'b0, 1'b0);
    do_move(2);
    expect_s("move5", 1'b1, {G0, G0, G0, G1}, 16'hEEED, 3'd0, 1'b1, 1'b0, 1'b0);
    do_move(2);
    do_next();
    expect_s("next1", 1'b1, {G0, G0, G0, G3}, 16'hEEE7, 3'd1, 1'b1, 1'b0, 1'b0);
    ButtonMove = 1'b1; ButtonNext = 1'b1; step();
    ButtonMove = 1'b0; ButtonNext = 1'b0; step();
    expect_s("mv_nx", 1'b1, {G0, G0, G0, G3}, 16'hEEE7, 3'd2, 1'b1, 1'b0, 1'b0);
    do_move(1);
    expect_s("d2", 1'b1, {G0, G1, G0, G3}, 16'hEDE7, 3'd2, 1'b1, 1'b0, 1'b0);
    do_next();
    do_tick(1);
    expect_s("onesec_enter", 1'b1, {G0, G1, G0, G3}, 16'hEDE7, 3'd3, 1'b1, 1'b0, 1'b0);
    final_next(1'b0, 16'hEDE7);
    expect_s("checkA", 1'b0, BLANK, 16'hEDE7, 3'd0, 1'b1, 1'b0, 1'b1);
    step();
    expect_s("idleA", 1'b1, BLANK, 16'hEDE7, 3'd0, 1'b0, 1'b0, 1'b0);
    do_move(1); do_next(); do_tick(1);
    expect_s("idle_ign", 1'b1, BLANK, 16'hEDE7, 3'd0, 1'b0, 1'b0, 1'b0);

    // Round B: exact target entered.
    Sequence_in = 16'hEDB7; display = 1'b1; step(); display = 1'b0;
    expect_s("showB", 1'b1, {G0, G1, G2, G3}, 16'hEDE7, 3'd0, 1'b1, 1'b0, 1'b0);
    do_tick(2);
    expect_s("enterB", 1'b1, ALL0, 16'hEEEE, 3'd0, 1'b1, 1'b0, 1'b0);
    do_move(3); do_next();
    do_move(2); do_next();
    do_move(1); do_next();
    final_next(1'b1, 16'hEDB7);
    expect_s("checkB", 1'b0, BLANK, 16'hEDB7, 3'd0, 1'b1, 1'b1, 1'b1);
    step();
    expect_s("idleB", 1'b1, BLANK, 16'hEDB7, 3'd0, 1'b0, 1'b1, 1'b0);

    // Round C: invalid target digit, then reset in SHOW.
    Sequence_in = 16'hEDB3; display = 1'b1; step(); display = 1'b0;
    expect_s("showC", 1'b1, {G0, G1, G2, GE}, 16'hEDB7, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    reset = 1'b1; #1;
    expect_s("rst_show", 1'b1, BLANK, 16'hEEEE, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); reset = 1'b0; step();

    // Round D: invalid target, display held high so a new round restarts.
    Sequence_in = 16'hEDB3; display = 1'b1; step();
    Sequence_in = 16'hE7DB;
    expect_s("showD", 1'b1, {G0, G1, G2, GE}, 16'hEEEE, 3'd0, 1'b1, 1'b0, 1'b0);
    do_tick(2);
    expect_s("enterD", 1'b1, ALL0, 16'hEEEE, 3'd0, 1'b1, 1'b0, 1'b0);
    do_next(); do_next(); do_next();
    final_next(1'b0, 16'hEEEE);
    expect_s("checkD", 1'b0, BLANK, 16'hEEEE, 3'd0, 1'b1, 1'b0, 1'b1);
    step();
    expect_s("idleD", 1'b1, BLANK, 16'hEEEE, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    display = 1'b0;
    expect_s("restart", 1'b1, {G0, G3, G1, G2}, 16'hEEEE, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    @(negedge clk);
    #1;

    tests++;
    if (exp_q.size() != 0 || done_exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: pending snapshots=%0d verdicts=%0d, required 0/0",
               exp_q.size(), done_exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
